// File: rtl/ntt_sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_sdf_stage_ctrl
//   Sequencer for one single-path delay-feedback NTT stage
//   (input mux -> FIFO -> butterfly -> output mux -> multiplier).
//   It turns an input valid/ready handshake into FIFO push/pop, mux selects,
//   butterfly enable and twiddle index. It also produces an output-valid
//   strobe that lines up with the multiplier result, and it drains the
//   buffered differences once the stream ends.
//
// Parameters
//   STEP     butterfly span D (also the FIFO depth); power of two, >= 2
//   MUL_LAT  multiplier latency in cycles (>= 0); delay applied to out_valid
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset (the FIFO shares this reset)
//   in_valid_i   incoming sample valid
//   in_last_i    final sample of the stream (qualified by in_valid_i)
//   in_ready_o   controller can accept a sample this cycle
//   fifo_push_o  FIFO push
//   fifo_pop_o   FIFO pop
//   mux1_sel_o   0: incoming -> FIFO, 1: butterfly difference -> FIFO
//   mux2_sel_o   0: FIFO output -> multiplier, 1: butterfly sum -> multiplier
//   bfly_en_o    butterfly enable
//   tw_idx_o     twiddle ROM index (entry 0 holds 1)
//   out_valid_o  multiplier result valid
//   busy_o       controller is not idle
//   err_o        sticky flag: in_last seen at an illegal position
// ---------------------------------------------------------------------------
module ntt_sdf_stage_ctrl #(
  parameter int unsigned STEP    = 4,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  input  logic                    in_last_i,
  output logic                    in_ready_o,
  output logic                    fifo_push_o,
  output logic                    fifo_pop_o,
  output logic                    mux1_sel_o,
  output logic                    mux2_sel_o,
  output logic                    bfly_en_o,
  output logic [$clog2(STEP)-1:0] tw_idx_o,
  output logic                    out_valid_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned     KW    = $clog2(STEP);
  localparam logic [KW-1:0]   KLAST = KW'(STEP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN_B,
    ST_RUN_A,
    ST_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          err_q, err_d;
  logic          accept;
  logic          strobe;

  assign in_ready_o = (state_q != ST_DRAIN);
  // Gating with rst_ni keeps push low while reset is held with in_valid high.
  assign accept     = in_valid_i & in_ready_o & rst_ni;
  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = err_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    err_d       = err_q;
    fifo_push_o = 1'b0;
    fifo_pop_o  = 1'b0;
    mux1_sel_o  = 1'b0;
    mux2_sel_o  = 1'b0;
    bfly_en_o   = 1'b0;
    tw_idx_o    = '0;
    strobe      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          fifo_push_o = 1'b1;
          k_d         = KW'(1);
          state_d     = ST_FILL;
        end
      end

      ST_FILL: begin
        if (accept) begin
          fifo_push_o = 1'b1;
          if (k_q == KLAST) begin
            k_d     = '0;
            state_d = ST_RUN_B;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      ST_RUN_B: begin
        if (accept) begin
          fifo_pop_o  = 1'b1;
          fifo_push_o = 1'b1;
          bfly_en_o   = 1'b1;
          mux1_sel_o  = 1'b1;
          mux2_sel_o  = 1'b1;
          strobe      = 1'b1;
          if (k_q == KLAST) begin
            k_d     = '0;
            state_d = in_last_i ? ST_DRAIN : ST_RUN_A;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      ST_RUN_A: begin
        // tw_idx follows k even on stalled cycles, so it holds while k holds.
        tw_idx_o = k_q;
        if (accept) begin
          fifo_pop_o  = 1'b1;
          fifo_push_o = 1'b1;
          strobe      = 1'b1;
          if (k_q == KLAST) begin
            k_d     = '0;
            state_d = ST_RUN_B;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      ST_DRAIN: begin
        tw_idx_o   = k_q;
        fifo_pop_o = 1'b1;
        strobe     = 1'b1;
        if (k_q == KLAST) begin
          k_d     = '0;
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      default: begin
        k_d     = '0;
        state_d = ST_IDLE;
      end
    endcase

    // The last butterfly slot is the only legal place for in_last.
    if (accept && in_last_i && !(state_q == ST_RUN_B && k_q == KLAST)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // The output strobe is delayed to line up with the multiplier result.
  generate
    if (MUL_LAT == 0) begin : g_no_delay
      assign out_valid_o = strobe;
    end else begin : g_delay
      logic [MUL_LAT-1:0] vpipe_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vpipe_q <= '0;
        end else begin
          vpipe_q <= (vpipe_q << 1) | MUL_LAT'(strobe);
        end
      end

      assign out_valid_o = vpipe_q[MUL_LAT-1];
    end
  endgenerate

endmodule
